// File: rtl/wavefront_mask_ctrl.sv
// Lane-mask shift-register sequencer: clear, fill, hold, drain per job.
// WAVEFRONT_REVERSE_DRAIN_EN: drain with right shifts (LIFO lane order).
module wavefront_mask_ctrl #(
    parameter int WIDTH  = 5,
    parameter int HOLD_W = 16,
    parameter int CNT_W  = $clog2(WIDTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [HOLD_W-1:0] hold_cycles,
    input  logic              advance,
    input  logic              abort,
    output logic              shift_in,
    output logic              direction_right,
    output logic              reset_zero,
    output logic              shift,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  active_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FILL,
        S_HOLD,
        S_DRAIN,
        S_DONE,
        S_ABORT
    } state_t;

`ifdef WAVEFRONT_REVERSE_DRAIN_EN
    localparam logic REV = 1'b1;
`else
    localparam logic REV = 1'b0;
`endif

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t state_q, state_d;
    logic [CNT_W-1:0] lane_q, lane_d;
    logic [CNT_W-1:0] active_q, active_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [HOLD_W-1:0] hcnt_q, hcnt_d;
    logic in_job;
    logic step;

    assign in_job = (state_q == S_CLEAR) || (state_q == S_FILL) ||
                    (state_q == S_HOLD) || (state_q == S_DRAIN);
    // abort outranks advance, so a step never happens on an aborting cycle
    assign step = advance && !abort;

    always_comb begin
        state_d         = state_q;
        lane_d          = lane_q;
        active_d        = active_q;
        hold_d          = hold_q;
        hcnt_d          = hcnt_q;
        start_ready     = 1'b0;
        shift_in        = 1'b0;
        direction_right = 1'b0;
        reset_zero      = 1'b0;
        shift           = 1'b0;
        done            = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    hold_d  = hold_cycles;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                reset_zero = 1'b1;
                active_d   = '0;
                lane_d     = '0;
                state_d    = S_FILL;
            end
            S_FILL: begin
                shift_in = 1'b1;
                shift    = step;
                if (step) begin
                    active_d = active_q + 1'b1;
                    if (lane_q == LAST) begin
                        lane_d  = '0;
                        hcnt_d  = '0;
                        state_d = (hold_q == '0) ? S_DRAIN : S_HOLD;
                    end else begin
                        lane_d = lane_q + 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (step) begin
                    if (hcnt_q == hold_q - 1'b1) begin
                        hcnt_d  = '0;
                        lane_d  = '0;
                        state_d = S_DRAIN;
                    end else begin
                        hcnt_d = hcnt_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                shift           = step;
                direction_right = REV;
                if (step) begin
                    active_d = active_q - 1'b1;
                    if (lane_q == LAST) begin
                        lane_d  = '0;
                        state_d = S_DONE;
                    end else begin
                        lane_d = lane_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            S_ABORT: begin
                reset_zero = 1'b1;
                active_d   = '0;
                lane_d     = '0;
                hcnt_d     = '0;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (in_job && abort) begin
            state_d = S_ABORT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            lane_q   <= '0;
            active_q <= '0;
            hold_q   <= '0;
            hcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            lane_q   <= lane_d;
            active_q <= active_d;
            hold_q   <= hold_d;
            hcnt_q   <= hcnt_d;
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign active_count = active_q;

endmodule

// File: tb/tb_wavefront_mask_ctrl.sv
// Scoreboarded bench for wavefront_mask_ctrl with a downstream mask model.
// Build with WAVEFRONT_REVERSE_DRAIN_EN to exercise the LIFO drain.
module tb_wavefront_mask_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_valid;
    logic        start_ready;
    logic [15:0] hold_cycles;
    logic        advance;
    logic        abort;
    logic        shift_in;
    logic        direction_right;
    logic        reset_zero;
    logic        shift;
    logic        busy;
    logic        done;
    logic [2:0]  active_count;

`ifdef WAVEFRONT_REVERSE_DRAIN_EN
    localparam bit REV = 1'b1;
`else
    localparam bit REV = 1'b0;
`endif

    wavefront_mask_ctrl #(.WIDTH(5), .HOLD_W(16)) dut (
        .clk(clk),
        .rst(rst),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .hold_cycles(hold_cycles),
        .advance(advance),
        .abort(abort),
        .shift_in(shift_in),
        .direction_right(direction_right),
        .reset_zero(reset_zero),
        .shift(shift),
        .busy(busy),
        .done(done),
        .active_count(active_count)
    );

    always #5 clk = ~clk;

    // Downstream mask register, driven only by the DUT's control outputs
    logic [4:0] mask_m = 5'b0;
    always @(posedge clk) begin
        if (reset_zero)
            mask_m <= 5'b0;
        else if (shift)
            mask_m <= direction_right ? {shift_in, mask_m[4:1]}
                                      : {mask_m[3:0], shift_in};
    end

    typedef struct {
        logic        rst;
        logic        sv;
        logic        adv;
        logic        ab;
        logic [15:0] h;
    } stim_t;

    typedef struct {
        logic [14:0] v;
        string       tag;
    } exp_t;

    stim_t stim_q[$];
    exp_t  exp_q[$];
    int    checks = 0;
    int    passed = 0;
    int    fails  = 0;
    int    cyc    = 0;
    logic [4:0] mexp = 5'b0;
    bit    tg;
    bit    phase;

    function automatic bit nadv();
        if (!tg) return 1'b1;
        phase = ~phase;
        return phase;
    endfunction

    task automatic add(input bit r, input bit sv, input bit a, input bit ab,
                       input int h, input bit sr, input bit bz, input bit dn,
                       input bit rz, input bit sh, input bit si, input bit dr,
                       input int ac, input string tag);
        stim_t s;
        exp_t  e;
        s.rst = r; s.sv = sv; s.adv = a; s.ab = ab; s.h = 16'(h);
        e.v   = {sr, bz, dn, rz, sh, si, dr, 3'(ac), mexp};
        e.tag = tag;
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    // Expected timeline of one job, from acceptance to the idle cycle after done
    task automatic plan_job(input int h, input bit tog, input bit svh,
                            input bit acc);
        int n;
        bit a;
        tg = tog;
        phase = 1'b0;
        if (acc) add(0, 1, 1, 0, h, 1, 0, 0, 0, 0, 0, 0, 0, "accept");
        a = nadv();
        add(0, svh, a, 0, h, 0, 1, 0, 1, 0, 0, 0, 0, "clear");
        mexp = 5'b0;
        n = 0;
        while (n < 5) begin
            a = nadv();
            add(0, svh, a, 0, h, 0, 1, 0, 0, a, 1, 0, n, "fill");
            if (a) begin
                mexp = {mexp[3:0], 1'b1};
                n++;
            end
        end
        n = 0;
        while (n < h) begin
            a = nadv();
            add(0, svh, a, 0, h, 0, 1, 0, 0, 0, 0, 0, 5, "hold");
            if (a) n++;
        end
        n = 0;
        while (n < 5) begin
            a = nadv();
            add(0, svh, a, 0, h, 0, 1, 0, 0, a, 0, REV, 5 - n, "drain");
            if (a) begin
                mexp = REV ? {1'b0, mexp[4:1]} : {mexp[3:0], 1'b0};
                n++;
            end
        end
        add(0, svh, 1, 0, h, 0, 1, 1, 0, 0, 0, 0, 0, "done");
        add(0, 0, 1, 0, h, 1, 0, 0, 0, 0, 0, 0, 0, "idle");
    endtask

    task automatic run();
        stim_t s;
        exp_t  e;
        logic [14:0] obs;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            rst         = s.rst;
            start_valid = s.sv;
            advance     = s.adv;
            abort       = s.ab;
            hold_cycles = s.h;
            @(negedge clk);
            e   = exp_q.pop_front();
            obs = {start_ready, busy, done, reset_zero, shift, shift_in,
                   direction_right, active_count, mask_m};
            checks++;
            assert (obs === e.v) passed++;
            else begin
                fails++;
                $error("FAIL %s cyc%0d got %h exp %h", e.tag, cyc, obs, e.v);
            end
            cyc++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        start_valid = 1'b0;
        advance = 1'b0;
        abort = 1'b0;
        hold_cycles = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        add(1, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, "reset");
        add(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, "idle_abort");
        run();

        plan_job(3, 0, 0, 1);
        run();
        plan_job(0, 0, 0, 1);
        run();
        plan_job(2, 1, 0, 1);
        run();

        add(0, 1, 1, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, "ab_accept");
        add(0, 0, 1, 0, 3, 0, 1, 0, 1, 0, 0, 0, 0, "ab_clear");
        mexp = 5'b0;
        for (int i = 0; i < 5; i++) begin
            add(0, 0, 1, 0, 3, 0, 1, 0, 0, 1, 1, 0, i, "ab_fill");
            mexp = {mexp[3:0], 1'b1};
        end
        add(0, 0, 1, 1, 3, 0, 1, 0, 0, 0, 0, 0, 5, "ab_hold");
        add(0, 0, 1, 0, 3, 0, 1, 0, 1, 0, 0, 0, 5, "ab_abort");
        mexp = 5'b0;
        add(0, 0, 1, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, "ab_idle");
        run();

        add(0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, "rs_accept");
        add(0, 1, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, "rs_clear");
        mexp = 5'b0;
        for (int i = 0; i < 3; i++) begin
            add(i == 2, 1, 1, 0, 1, 0, 1, 0, 0, 1, 1, 0, i, "rs_fill");
            mexp = {mexp[3:0], 1'b1};
        end
        add(0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, "rs_idle");
        plan_job(1, 0, 1, 0);
        run();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/wavefront_mask_ctrl.md
Name: wavefront_mask_ctrl

Overview:
Control sequencer that drives a dual-direction lane-mask shift register (clear, shift, direction and shift-in bit) in the hyperspectral LCMV systolic datapath.
On each accepted job it clears the mask, fills it one lane per advance step, holds it for a programmable number of steps, then drains it lane by lane.
It also tracks the number of active lanes and pulses done when the job completes.
It sits directly upstream of the mask register and is paced by the array's advance strobe.

Parameters:
WIDTH, 5, number of lanes in the downstream mask register (must be >= 2)
HOLD_W, 16, width of the hold-cycle count
CNT_W, $clog2(WIDTH+1), width of the lane counter and active_count

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
start_valid  input  1  job request
start_ready  output  1  high only in IDLE; a job is accepted when start_valid && start_ready
hold_cycles  input  HOLD_W  number of advance steps in HOLD; captured at acceptance
advance  input  1  pacing strobe from the array; FILL, HOLD and DRAIN progress only when it is high
abort  input  1  cancels the job in progress
shift_in  output  1  bit shifted into the mask register
direction_right  output  1  1 = shift right, 0 = shift left
reset_zero  output  1  clears the mask register
shift  output  1  shift enable to the mask register
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse at normal job completion
active_count  output  CNT_W  number of 1s in the downstream mask, as modelled by this block

Behaviour:
- Reset: rst is synchronous, active-high, on clock clk.
  - State goes to IDLE; lane and hold counters go to 0; active_count = 0.
  - All outputs are 0 except start_ready = 1.
  - Reset mid-job returns to IDLE on the next edge, with no done pulse.
- States: IDLE, CLEAR, FILL, HOLD, DRAIN, DONE, ABORT.
- IDLE:
  - start_ready = 1.
  - On accept: latch hold_cycles, go to CLEAR.
  - start_valid in any other state is ignored.
- CLEAR (1 cycle, independent of advance):
  - reset_zero = 1, active_count <= 0, lane counter <= 0.
  - Next state is FILL.
- FILL:
  - shift = advance, shift_in = 1, direction_right = 0.
  - Each advance cycle increments the lane counter and active_count.
  - After WIDTH advance cycles: go to HOLD, or straight to DRAIN if the latched hold = 0.
- HOLD:
  - shift = 0; counts latched-hold advance cycles, then goes to DRAIN.
  - Lane counter resets to 0 on entry to DRAIN.
- DRAIN:
  - shift = advance, shift_in = 0, direction_right = 0 (left shift).
  - Lanes empty in the same order they filled, bit 0 first.
  - Each advance cycle decrements active_count.
  - After WIDTH advance cycles: go to DONE.
- DONE (1 cycle): done = 1, then IDLE.
- ABORT:
  - abort while in CLEAR, FILL, HOLD or DRAIN goes to ABORT on the next edge.
  - ABORT lasts 1 cycle: reset_zero = 1, active_count <= 0, then IDLE; no done pulse.
  - abort in IDLE, DONE or ABORT is ignored.
- Priority: rst > abort > advance.
- Output timing:
  - Outputs are combinational decodes of the registered state and advance; shift never asserts outside FILL and DRAIN.
  - shift_in, reset_zero, shift and direction_right are 0 in every state where they are not listed above.
- Latency with advance held at 1, accept at cycle 0:
  - CLEAR at cycle 1.
  - FILL at cycles 2..WIDTH+1.
  - HOLD for H cycles.
  - DRAIN for WIDTH cycles.
  - done at cycle 2*WIDTH+H+2.
  - start_ready high again on the following cycle.
- Arithmetic: active_count stays within 0..WIDTH.
- Counters: hold counter is HOLD_W bits; the maximum hold is 2^HOLD_W-1 with no wrap.

Optional Feature:
- Macro: WAVEFRONT_REVERSE_DRAIN_EN.
- Defined: DRAIN drives direction_right = 1 with shift_in = 0 (LIFO order). The modelled mask steps 11111 -> 01111 -> 00111 -> ...
- Undefined: direction_right is tied to 0 in all states.
- Counts, timing and handshakes are identical in both builds.

Test Plan:
- WIDTH=5, hold=3, advance=1, accept at cycle 0 -> reset_zero at cycle 1; shift=1/shift_in=1 at cycles 2-6; shift=0 at cycles 7-9; shift=1/shift_in=0/direction_right=0 at cycles 10-14; done at cycle 15; start_ready=1 at cycle 16; active_count steps 0..5..0.
- hold=0 -> DRAIN directly follows FILL at cycle 7; done at cycle 12; no shift=0 gap between fill and drain.
- advance toggling 1,0,1,0... -> exactly 5 fill shifts and 5 drain shifts; shift=0 whenever advance=0; active_count frozen on stalled cycles.
- abort in HOLD with active_count=5 -> next cycle state ABORT with reset_zero=1; following cycle IDLE with active_count=0; done never asserts.
- rst asserted at the third FILL cycle -> next cycle IDLE with all outputs 0 and start_ready=1; start_valid held during busy is ignored and accepted only once back in IDLE.
- WAVEFRONT_REVERSE_DRAIN_EN defined, hold=1 -> direction_right=1 for all 5 drain cycles; a reference mask model reads 11111, 01111, 00111, 00011, 00001, 00000.
